// File: rtl/ibex_defines.sv
// Shared definitions for the eFPGA custom-op dispatcher: FSM state encoding
// and the default WAIT-state timeout.
package ibex_defines;

    localparam int EFPGA_TIMEOUT_DEFAULT = 32;

    typedef enum logic [1:0] {
        DISP_IDLE   = 2'd0,
        DISP_LAUNCH = 2'd1,
        DISP_WAIT   = 2'd2,
        DISP_RESP   = 2'd3
    } efpga_disp_state_e;

endpackage

// File: rtl/ibex_efpga_perf_cnt.sv
// Performance counters for the eFPGA dispatcher: completed ops and total WAIT
// cycles, both free-running and wrapping at 2^32.
module ibex_efpga_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_done,
    input  logic        wait_cycle,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_wait
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops  <= '0;
            perf_wait <= '0;
        end else begin
            if (op_done)    perf_ops  <= perf_ops + 32'd1;
            if (wait_cycle) perf_wait <= perf_wait + 32'd1;
        end
    end

endmodule

// File: rtl/ibex_efpga_dispatch.sv
// Dispatches ID-stage custom ops to the eFPGA and returns results with timeout.
// Build macro EFPGA_DISPATCH_PERF_EN adds the op/wait performance counters.
//
// state       | meaning
// ------------+---------------------------------------------------------
// DISP_IDLE   | ready for a request; payload latched on accept
// DISP_LAUNCH | one-cycle launch strobe to the eFPGA, timeout cleared
// DISP_WAIT   | waiting for eFPGA completion or timeout
// DISP_RESP   | response held until writeback accepts it
module ibex_efpga_dispatch
    import ibex_defines::*;
#(
    parameter int TIMEOUT_CYCLES = EFPGA_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_operator_i,
    input  logic [31:0] req_operand_a_i,
    input  logic [31:0] req_operand_b_i,
    input  logic [3:0]  req_delay_i,
    output logic        efpga_en_o,
    output logic [1:0]  efpga_operator_o,
    output logic [31:0] efpga_operand_a_o,
    output logic [31:0] efpga_operand_b_o,
    output logic [3:0]  efpga_delay_o,
    input  logic        efpga_ready_i,
    input  logic [31:0] efpga_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_error_o,
    output logic        busy_o,
    output logic [31:0] perf_ops_o,
    output logic [31:0] perf_wait_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    efpga_disp_state_e state_q, state_d;
    logic [7:0]        cnt_q;
    logic              accept;
    logic              ready_c;

    always_comb begin
        state_d     = state_q;
        ready_c     = 1'b0;
        accept      = 1'b0;
        efpga_en_o  = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = (state_q != DISP_IDLE);
        case (state_q)
            DISP_IDLE: begin
                ready_c = 1'b1;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = DISP_LAUNCH;
                end
            end
            DISP_LAUNCH: begin
                efpga_en_o = 1'b1;
                state_d    = DISP_WAIT;
            end
            DISP_WAIT: begin
                if (efpga_ready_i || (cnt_q == TIMEOUT_LAST)) state_d = DISP_RESP;
            end
            DISP_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    ready_c = 1'b1;
                    if (req_valid_i) begin
                        accept  = 1'b1;
                        state_d = DISP_LAUNCH;
                    end else begin
                        state_d = DISP_IDLE;
                    end
                end
            end
            default: state_d = DISP_IDLE;
        endcase
    end

    // No request may be advertised as accepted while reset is held.
    assign req_ready_o = ready_c & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= DISP_IDLE;
            cnt_q             <= '0;
            efpga_operator_o  <= '0;
            efpga_operand_a_o <= '0;
            efpga_operand_b_o <= '0;
            efpga_delay_o     <= '0;
            rsp_result_o      <= '0;
            rsp_error_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                efpga_operator_o  <= req_operator_i;
                efpga_operand_a_o <= req_operand_a_i;
                efpga_operand_b_o <= req_operand_b_i;
                efpga_delay_o     <= req_delay_i;
            end
            if (state_q == DISP_LAUNCH)    cnt_q <= '0;
            else if (state_q == DISP_WAIT) cnt_q <= cnt_q + 8'd1;
            // Completion takes priority over a timeout in the same cycle.
            if (state_q == DISP_WAIT) begin
                if (efpga_ready_i) begin
                    rsp_result_o <= efpga_result_i;
                    rsp_error_o  <= 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rsp_result_o <= '0;
                    rsp_error_o  <= 1'b1;
                end
            end
        end
    end

`ifdef EFPGA_DISPATCH_PERF_EN
    logic op_done;
    logic wait_cycle;

    assign op_done    = (state_q == DISP_RESP) & rsp_ready_i & ~rsp_error_o;
    assign wait_cycle = (state_q == DISP_WAIT);

    ibex_efpga_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_done    (op_done),
        .wait_cycle (wait_cycle),
        .perf_ops   (perf_ops_o),
        .perf_wait  (perf_wait_o)
    );
`else
    assign perf_ops_o  = '0;
    assign perf_wait_o = '0;
`endif

endmodule

// File: tb/tb_ibex_efpga_dispatch.sv
// Directed self-checking bench for ibex_efpga_dispatch with a simple eFPGA model
// that completes delay+2 cycles after each launch strobe.
module tb_ibex_efpga_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_operator_i;
    logic [31:0] req_operand_a_i;
    logic [31:0] req_operand_b_i;
    logic [3:0]  req_delay_i;
    logic        efpga_en_o;
    logic [1:0]  efpga_operator_o;
    logic [31:0] efpga_operand_a_o;
    logic [31:0] efpga_operand_b_o;
    logic [3:0]  efpga_delay_o;
    logic        efpga_ready_i = 1'b0;
    logic [31:0] efpga_result_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_error_o;
    logic        busy_o;
    logic [31:0] perf_ops_o;
    logic [31:0] perf_wait_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic        model_hang   = 1'b0;
    logic        inject       = 1'b0;
    logic [31:0] model_result = '0;
    int          m_cnt        = 0;

    int cyc     = 0;
    int en_cnt  = 0;
    int last_en = 0;
    int prev_en = 0;

    always #5 clk = ~clk;

    ibex_efpga_dispatch #(.TIMEOUT_CYCLES(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_operator_i    (req_operator_i),
        .req_operand_a_i   (req_operand_a_i),
        .req_operand_b_i   (req_operand_b_i),
        .req_delay_i       (req_delay_i),
        .efpga_en_o        (efpga_en_o),
        .efpga_operator_o  (efpga_operator_o),
        .efpga_operand_a_o (efpga_operand_a_o),
        .efpga_operand_b_o (efpga_operand_b_o),
        .efpga_delay_o     (efpga_delay_o),
        .efpga_ready_i     (efpga_ready_i),
        .efpga_result_i    (efpga_result_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_result_o      (rsp_result_o),
        .rsp_error_o       (rsp_error_o),
        .busy_o            (busy_o),
        .perf_ops_o        (perf_ops_o),
        .perf_wait_o       (perf_wait_o)
    );

    // eFPGA model: drives ready 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        efpga_ready_i  = 1'b0;
        efpga_result_i = '0;
        if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                efpga_ready_i  = 1'b1;
                efpga_result_i = model_result;
            end
        end
        if (inject) begin
            efpga_ready_i  = 1'b1;
            efpga_result_i = 32'hCAFE0001;
        end
        if (efpga_en_o && !model_hang) m_cnt = int'(efpga_delay_o) + 2;
        if (!rst_n) m_cnt = 0;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (efpga_en_o) begin
            en_cnt  = en_cnt + 1;
            prev_en = last_en;
            last_en = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] d);
        req_valid_i     = 1'b1;
        req_operator_i  = op;
        req_operand_a_i = a;
        req_operand_b_i = b;
        req_delay_i     = d;
    endtask

    // Present a request from IDLE and return in its LAUNCH cycle.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] d);
        drive_req(op, a, b, d);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy_o) break;
        end
        check("accept", busy_o, 1'b1);
        req_valid_i = 1'b0;
    endtask

    // Tick until rsp_valid_o; n is the number of ticks taken.
    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        while (!rsp_valid_o && n < budget) begin
            tick();
            n++;
        end
        check("rsp_seen", rsp_valid_o, 1'b1);
    endtask

    int n;
    int en_before;

    initial begin
        rst_n           = 1'b0;
        req_valid_i     = 1'b0;
        req_operator_i  = '0;
        req_operand_a_i = '0;
        req_operand_b_i = '0;
        req_delay_i     = '0;
        rsp_ready_i     = 1'b0;
        repeat (3) tick();

        check("rst_busy", busy_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_en", efpga_en_o, 1'b0);
        check("rst_req_ready", req_ready_o, 1'b0);
        check("rst_result", rsp_result_o, 32'h0);
        check("rst_perf_ops", perf_ops_o, 32'h0);

        // Single op, request presented in the first cycle out of reset.
        model_result = 32'hDEADBEEF;
        rst_n = 1'b1;
        drive_req(2'b01, 32'h11, 32'h22, 4'd3);
        #1;
        check("first_req_ready", req_ready_o, 1'b1);
        tick();
        check("first_accept", busy_o, 1'b1);
        req_valid_i = 1'b0;
        en_before = en_cnt;
        check("launch_en", efpga_en_o, 1'b1);
        check("launch_req_ready", req_ready_o, 1'b0);
        check("launch_op", efpga_operator_o, 32'h1);
        check("launch_a", efpga_operand_a_o, 32'h11);
        check("launch_b", efpga_operand_b_o, 32'h22);
        tick();
        check("wait_en_low", efpga_en_o, 1'b0);
        check("wait_req_ready", req_ready_o, 1'b0);
        wait_rsp(40, n);
        check("latency_d3", n + 2, 32'd7);
        check("result_d3", rsp_result_o, 32'hDEADBEEF);
        check("error_d3", rsp_error_o, 1'b0);
        check("en_pulses_d3", en_cnt - en_before, 32'd1);
        check("payload_held", efpga_delay_o, 32'd3);

        // Writeback stalled for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", rsp_valid_o, 1'b1);
            check("stall_result", rsp_result_o, 32'hDEADBEEF);
            check("stall_req_ready", req_ready_o, 1'b0);
            check("stall_busy", busy_o, 1'b1);
        end
        rsp_ready_i = 1'b1;
        tick();
        check("idle_after_rsp", busy_o, 1'b0);
        check("idle_rsp_valid", rsp_valid_o, 1'b0);

        // Ready pulse in IDLE is ignored.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick();
        check("ign_busy", busy_o, 1'b0);
        check("ign_rsp_valid", rsp_valid_o, 1'b0);
        check("ign_result", rsp_result_o, 32'hDEADBEEF);

        // Timeout: model never completes.
        model_hang = 1'b1;
        send(2'b10, 32'h5, 32'h6, 4'd1);
        wait_rsp(60, n);
        check("timeout_wait_cycles", n - 1, 32'd32);
        check("timeout_result", rsp_result_o, 32'h0);
        check("timeout_error", rsp_error_o, 1'b1);
        tick();
        check("timeout_idle", busy_o, 1'b0);

        // Completion on the final timeout cycle wins.
        send(2'b11, 32'h7, 32'h8, 4'd1);
        repeat (31) tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check("edge_still_wait", rsp_valid_o, 1'b0);
        tick();
        check("edge_valid", rsp_valid_o, 1'b1);
        check("edge_result", rsp_result_o, 32'hCAFE0001);
        check("edge_error", rsp_error_o, 1'b0);
        tick();

        // Back-to-back with rsp_ready_i held high.
        model_hang   = 1'b0;
        model_result = 32'h1234_5678;
        send(2'b01, 32'hA1, 32'hB1, 4'd2);
        drive_req(2'b10, 32'hA2, 32'hB2, 4'd2);
        check("b2b_payload_held", efpga_operand_a_o, 32'hA1);
        wait_rsp(40, n);
        check("b2b_result1", rsp_result_o, 32'h1234_5678);
        check("b2b_req_ready", req_ready_o, 1'b1);
        check("b2b_payload_wait", efpga_operand_b_o, 32'hB1);
        model_result = 32'h8765_4321;
        tick();
        req_valid_i = 1'b0;
        check("b2b_launch2", efpga_en_o, 1'b1);
        check("b2b_a2", efpga_operand_a_o, 32'hA2);
        wait_rsp(40, n);
        check("b2b_result2", rsp_result_o, 32'h8765_4321);
        check("b2b_en_gap", last_en - prev_en, 32'd6);
        tick();
        check("b2b_idle", busy_o, 1'b0);

        // Reset during WAIT with a completion pulse right after.
        model_hang = 1'b1;
        send(2'b11, 32'hFF, 32'hEE, 4'd5);
        tick();
        tick();
        rst_n  = 1'b0;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
        check("mid_rst_a", efpga_operand_a_o, 32'h0);
        check("mid_rst_op", efpga_operator_o, 32'h0);
        check("mid_rst_result", rsp_result_o, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_rsp_valid", rsp_valid_o, 1'b0);
        check("post_rst_req_ready", req_ready_o, 1'b1);

        // Three delay-0 ops for the performance counters.
        model_hang   = 1'b0;
        model_result = 32'h0000_0042;
        for (int k = 0; k < 3; k++) begin
            send(2'b00, 32'(k), 32'h0, 4'd0);
            wait_rsp(20, n);
            check("perf_op_result", rsp_result_o, 32'h42);
            tick();
        end
`ifdef EFPGA_DISPATCH_PERF_EN
        check("perf_ops", perf_ops_o, 32'd3);
        check("perf_wait", perf_wait_o, 32'd6);
`else
        check("perf_ops", perf_ops_o, 32'd0);
        check("perf_wait", perf_wait_o, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
